// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Sits in front of a 16-bit combinational ALU.
//   - It queues operand/opcode commands in a DEPTH-entry FIFO.
//   - It presents the FIFO head to the ALU.
//   - It registers the ALU result into a valid/ready output stage.
//   - It counts the results that the consumer accepts.
//
// Optional feature: define ALU_ISSUE_FLAGS_EN to add the registered out_zero
// and out_neg result flags.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     command handshake; in_a, in_b, in_opcode payload
//   alu_a/alu_b/alu_opcode
//                         FIFO head fields to the ALU, or zero when empty
//   alu_result            combinational ALU result for the current head
//   out_valid/out_ready   result handshake; out_result, out_opcode payload
//   fifo_count            number of commands held in the FIFO
//   done_count            results accepted by the consumer (wraps)
//   out_zero, out_neg     result flags (present only with ALU_ISSUE_FLAGS_EN)
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    input  logic [2:0]               in_opcode,
    output logic [15:0]              alu_a,
    output logic [15:0]              alu_b,
    output logic [2:0]               alu_opcode,
    input  logic [15:0]              alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_result,
    output logic [2:0]               out_opcode,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         done_count
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic                     out_zero,
    output logic                     out_neg
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [15:0]     r_mem_a  [DEPTH];
    logic [15:0]     r_mem_b  [DEPTH];
    logic [2:0]      r_mem_op [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_result;
    logic [2:0]      r_opcode;
    logic [CNT_W-1:0] r_done;
`ifdef ALU_ISSUE_FLAGS_EN
    logic            r_zero;
    logic            r_neg;
`endif

    logic w_nonempty;
    logic w_push;
    logic w_pop;
    logic w_accept;

    assign w_nonempty = (r_count != '0);
    // A full FIFO refuses commands even when a pop happens in the same
    // cycle, so in_ready depends only on registered state.
    assign in_ready   = (r_count < CW'(DEPTH));
    assign w_push     = in_valid & in_ready;
    assign out_valid  = (r_state == S_FULL);
    assign w_accept   = out_valid & out_ready;
    assign w_pop      = w_nonempty & (~out_valid | out_ready);

    assign out_result = r_result;
    assign out_opcode = r_opcode;
    assign fifo_count = r_count;
    assign done_count = r_done;
`ifdef ALU_ISSUE_FLAGS_EN
    assign out_zero   = r_zero;
    assign out_neg    = r_neg;
`endif

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        if (w_nonempty) begin
            alu_a      = r_mem_a[r_head];
            alu_b      = r_mem_b[r_head];
            alu_opcode = r_mem_op[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_EMPTY;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_opcode <= '0;
            r_done   <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_mem_a[r_tail]  <= in_a;
                r_mem_b[r_tail]  <= in_b;
                r_mem_op[r_tail] <= in_opcode;
                r_tail           <= r_tail + AW'(1);
            end

            if (w_pop) begin
                r_result <= alu_result;
                r_opcode <= r_mem_op[r_head];
                r_head   <= r_head + AW'(1);
`ifdef ALU_ISSUE_FLAGS_EN
                r_zero   <= (alu_result == '0);
                r_neg    <= alu_result[15];
`endif
            end

            // In FULL, a pop implies out_ready, so FULL with a pop stays
            // FULL back-to-back.
            if (r_state == S_EMPTY) begin
                if (w_pop) r_state <= S_FULL;
            end else begin
                if (out_ready && !w_pop) r_state <= S_EMPTY;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end

            if (w_accept) begin
                r_done <= r_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_opcode;
    logic [2:0]  fifo_count;
    logic [15:0] done_count;
`ifdef ALU_ISSUE_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .fifo_count (fifo_count),
        .done_count (done_count)
`ifdef ALU_ISSUE_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_neg    (out_neg)
`endif
    );

    // External combinational ALU that the stage feeds
    always_comb begin
        case (alu_opcode)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = alu_a << 1;
            default: alu_result = alu_a >> 1;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
    endtask

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [2:0]  vop[8];
    logic [15:0] vres[8];

    initial begin
        va   = '{16'h0000, 16'h8001, 16'h8001, 16'hFFFF, 16'hF0F0, 16'hF0F0, 16'hAAAA, 16'h00FF};
        vb   = '{16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'hFF00, 16'h0F0F, 16'hFFFF, 16'h0000};
        vop  = '{3'b001,   3'b110,   3'b111,   3'b000,   3'b010,   3'b011,   3'b100,   3'b101};
        vres = '{16'hFFFF, 16'h0002, 16'h4000, 16'h0001, 16'hF000, 16'hFFFF, 16'h5555, 16'hFF00};

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 3'b000);
        step();
        step();

        // Reset state
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_alu_a",      32'(alu_a),      32'd0);
        rst = 1'b0;

        // Single command, 1-cycle latency
        drive(1'b1, 16'h0003, 16'h0005, 3'b000);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'b000);
        chk("t1_count_after_push", 32'(fifo_count), 32'd1);
        chk("t1_valid_after_push", 32'(out_valid),  32'd0);
        chk("t1_alu_a",            32'(alu_a),      32'h0003);
        chk("t1_alu_b",            32'(alu_b),      32'h0005);
        step();
        chk("t1_out_valid",  32'(out_valid),  32'd1);
        chk("t1_out_result", 32'(out_result), 32'h0008);
        chk("t1_out_opcode", 32'(out_opcode), 32'd0);
        chk("t1_count_empty", 32'(fifo_count), 32'd0);
        step();
        chk("t1_done_count", 32'(done_count), 32'd1);
        chk("t1_valid_clear", 32'(out_valid), 32'd0);

        // Backpressure: 1 result held + 4 queued, next command refused
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(i), 16'h0010, 3'b000);
            step();
        end
        chk("t2_in_ready_full", 32'(in_ready),   32'd0);
        chk("t2_count_full",    32'(fifo_count), 32'd4);
        chk("t2_held_valid",    32'(out_valid),  32'd1);
        chk("t2_held_result",   32'(out_result), 32'h0010);
        drive(1'b1, 16'h0005, 16'h0010, 3'b000);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'b000);
        chk("t2_count_after_drop", 32'(fifo_count), 32'd4);
        chk("t2_held_stable",      32'(out_result), 32'h0010);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t2_drain_valid",  32'(out_valid),  32'd1);
            chk("t2_drain_result", 32'(out_result), 32'h0010 + 32'(k));
            step();
        end
        chk("t2_drained_valid", 32'(out_valid),  32'd0);
        chk("t2_drained_count", 32'(fifo_count), 32'd0);
        chk("t2_done_count",    32'(done_count), 32'd6);

        // Back-to-back stream of 8 commands
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, va[i], vb[i], vop[i]);
            step();
            if (i > 0) begin
                chk("t3_stream_valid",  32'(out_valid),  32'd1);
                chk("t3_stream_result", 32'(out_result), 32'(vres[i-1]));
                chk("t3_stream_opcode", 32'(out_opcode), 32'(vop[i-1]));
            end
        end
        drive(1'b0, 16'h0, 16'h0, 3'b000);
        step();
        chk("t3_last_valid",  32'(out_valid),  32'd1);
        chk("t3_last_result", 32'(out_result), 32'hFF00);
        step();
        chk("t3_end_valid", 32'(out_valid),  32'd0);
        chk("t3_done",      32'(done_count), 32'd14);

        // Reset with 3 queued and a held result; reset beats push/pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h00F0, 16'h0F00, 3'b011);
            step();
        end
        chk("t4_pre_count", 32'(fifo_count), 32'd3);
        chk("t4_pre_valid", 32'(out_valid),  32'd1);
        chk("t4_pre_result", 32'(out_result), 32'h0FF0);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 3'b000);
        chk("t4_count",      32'(fifo_count), 32'd0);
        chk("t4_valid",      32'(out_valid),  32'd0);
        chk("t4_result",     32'(out_result), 32'd0);
        chk("t4_opcode",     32'(out_opcode), 32'd0);
        chk("t4_done",       32'(done_count), 32'd0);
        chk("t4_alu_a",      32'(alu_a),      32'd0);
        chk("t4_alu_b",      32'(alu_b),      32'd0);
        chk("t4_alu_opcode", 32'(alu_opcode), 32'd0);

        // done_count wrap: after edge k of a stream, done_count = k-2
        drive(1'b1, 16'h0001, 16'h0001, 3'b000);
        for (int k = 0; k < 65537; k++) begin
            step();
        end
        chk("t5_done_max", 32'(done_count), 32'hFFFF);
        chk("t5_valid",    32'(out_valid),  32'd1);
        drive(1'b0, 16'h0, 16'h0, 3'b000);
        step();
        chk("t5_done_wrap", 32'(done_count), 32'h0000);
        step();
        chk("t5_idle_valid", 32'(out_valid), 32'd0);

`ifdef ALU_ISSUE_FLAGS_EN
        // Result flags
        drive(1'b1, 16'h1234, 16'h1234, 3'b100);
        step();
        drive(1'b1, 16'h0000, 16'h0000, 3'b101);
        step();
        chk("t6_xor_result", 32'(out_result), 32'h0000);
        chk("t6_xor_zero",   32'(out_zero),   32'd1);
        chk("t6_xor_neg",    32'(out_neg),    32'd0);
        drive(1'b0, 16'h0, 16'h0, 3'b000);
        step();
        chk("t6_not_result", 32'(out_result), 32'hFFFF);
        chk("t6_not_zero",   32'(out_zero),   32'd0);
        chk("t6_not_neg",    32'(out_neg),    32'd1);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Command-side stage directly upstream of the 16-bit combinational ALU (3-bit opcode: ADD, SUB, AND, OR, XOR, NOT, SHL1, SHR1).
- Buffers operand/opcode commands in a small FIFO and drives the ALU operand inputs from the FIFO head.
- Captures the ALU result into a registered output with a valid/ready handshake.
- Decouples the command producer from the result consumer and counts completed operations.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  FIFO can accept a command
- in_a  input  16  operand A
- in_b  input  16  operand B
- in_opcode  input  3  ALU opcode
- alu_a  output  16  to ALU a
- alu_b  output  16  to ALU b
- alu_opcode  output  3  to ALU opcode
- alu_result  input  16  from ALU result (combinational, same cycle)
- out_valid  output  1  out_result holds an unconsumed result
- out_ready  input  1  consumer accepts result
- out_result  output  16  registered ALU result
- out_opcode  output  3  opcode that produced out_result
- fifo_count  output  $clog2(DEPTH)+1  entries currently held
- done_count  output  CNT_W  results accepted by consumer, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at a clk edge): FIFO emptied, fifo_count=0, out_valid=0, out_result=0, out_opcode=0, done_count=0. Reset wins over any simultaneous push, pop or drain. A command or result in flight is discarded.
- in_ready = (fifo_count < DEPTH). It is low when full even if a pop occurs the same cycle; no full-bypass.
- Push = in_valid & in_ready. The entry is written at the tail; in_valid while in_ready=0 is ignored, with no state change.
- alu_a/alu_b/alu_opcode = FIFO head fields when fifo_count>0, else 0/0/3'b000.
- Output register has two states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- can_load = (fifo_count>0) & (~out_valid | out_ready).
- Pop = can_load. On pop, out_result<=alu_result and out_opcode<=head opcode; the head pointer advances.
- Transitions:
  - EMPTY->FULL on pop.
  - FULL->FULL on out_ready with pop (back-to-back, one result per cycle).
  - FULL->EMPTY on out_ready without pop.
  - FULL holds while out_ready=0. out_result/out_opcode remain stable until accepted.
- done_count increments by 1 on each cycle with out_valid & out_ready; wraps from all-ones to 0.
- fifo_count updates as +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle. Pointers wrap modulo DEPTH.
- Latency: command pushed at edge N is at the ALU inputs after N, captured at edge N+1, out_valid=1 after N+1 (1 cycle, empty pipe, out_ready=1).
- Sustained throughput is 1 command/cycle with in_valid=out_ready=1.
- Ordering: results emerge strictly in push order.
- ALU arithmetic is the ALU's own: 16-bit wrap on ADD/SUB, no carry captured here.

Optional Feature:
- Macro: ALU_ISSUE_FLAGS_EN.
- When defined, two extra outputs are present: out_zero (1) and out_neg (1), registered alongside out_result on pop.
  - out_zero = (alu_result==0); out_neg = alu_result[15].
  - Both reset to 0 and hold while FULL.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then push a=0x0003 b=0x0005 op=000 with out_ready=1 -> one cycle later out_valid=1, out_result=0x0008, out_opcode=000; done_count=1 after accept.
- out_ready=0, push 5 commands (DEPTH=4) -> first result held in output register, fifo_count=4, in_ready=0, fifth command dropped; release out_ready -> 5 results in push order, none for the dropped command.
- Stream 8 commands back-to-back with in_valid=out_ready=1 -> out_valid high 8 consecutive cycles. Results include: op 001 a=0x0000 b=0x0001 -> 0xFFFF; op 110 a=0x8001 -> 0x0002; op 111 a=0x8001 -> 0x4000.
- Assert rst with 3 entries queued and out_valid=1 -> next cycle fifo_count=0, out_valid=0, out_result=0, done_count=0; alu_a/alu_b/alu_opcode=0.
- Preload done_count to 0xFFFF via 65535 accepts (or force) and accept once more -> done_count=0x0000.
- With ALU_ISSUE_FLAGS_EN: op 100 a=b=0x1234 -> out_zero=1, out_neg=0; op 101 a=0x0000 -> out_result=0xFFFF, out_neg=1, out_zero=0.
